// File: rtl/ext_dma_device.sv
// Simulated external DMA source: counts down, raises an interrupt, then serves
// fixed-latency burst reads from a reset-initialised, read-only word memory.
module ext_dma_device #(
  parameter int unsigned          WORD_SIZE = 16,
  parameter int unsigned          DEPTH     = 12,
  parameter int unsigned          BURST_LEN = 4,
  parameter int unsigned          DELAY     = 64,
  parameter int unsigned          READ_LAT  = 2,
  parameter logic [WORD_SIZE-1:0] INIT_BASE = 16'h0100,
  parameter bit                   REPEAT    = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           intr_ack,
  input  logic                           rd_req,
  input  logic [WORD_SIZE-1:0]           offset,
  output logic                           interrupt,
  output logic                           busy,
  output logic                           rd_valid,
  output logic                           rd_err,
  output logic [WORD_SIZE*BURST_LEN-1:0] data,
  output logic                           done
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW = $clog2(DELAY);
  localparam int unsigned LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int unsigned CW = $clog2(DEPTH + BURST_LEN + 1);
  localparam int unsigned RW = (WORD_SIZE + 1 > 17) ? WORD_SIZE + 1 : 17;
  localparam int unsigned DW = WORD_SIZE * BURST_LEN;

  typedef enum logic [1:0] {S_COUNT, S_INTR, S_SERVE, S_HALT} state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [LW-1:0]          lat_q, lat_d;
  logic [WORD_SIZE-1:0]   off_q, off_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   interrupt_q, interrupt_d;
  logic                   busy_q, busy_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   rd_err_q, rd_err_d;
  logic                   done_q, done_d;
  logic [DW-1:0]          data_q, data_d;
  logic [WORD_SIZE-1:0]   mem_q [DEPTH];

  logic [DW-1:0]          burst_c;
  logic                   in_range_c;
  logic [CW-1:0]          cnt_sum_c;

  // Range check is done wide enough that offset+BURST_LEN cannot wrap.
  assign in_range_c = (RW'(off_q) + RW'(BURST_LEN)) <= RW'(DEPTH);
  assign cnt_sum_c  = cnt_q + CW'(BURST_LEN);

  // Lowest-addressed word lands in the MSBs of the burst.
  always_comb begin
    burst_c = '0;
    for (int unsigned b = 0; b < BURST_LEN; b++) begin
      burst_c[(BURST_LEN-1-b)*WORD_SIZE +: WORD_SIZE] = mem_q[AW'(off_q) + AW'(b)];
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    lat_d       = lat_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    interrupt_d = interrupt_q;
    busy_d      = busy_q;
    data_d      = data_q;
    rd_valid_d  = 1'b0;
    rd_err_d    = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_COUNT: begin
        if (timer_q == '0) begin
          state_d     = S_INTR;
          interrupt_d = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_INTR: begin
        if (intr_ack) begin
          state_d     = S_SERVE;
          interrupt_d = 1'b0;
        end
      end
      S_SERVE: begin
        if (!busy_q) begin
          if (rd_req) begin
            busy_d = 1'b1;
            off_d  = offset;
            lat_d  = LW'(READ_LAT - 1);
          end
        end else if (lat_q != '0) begin
          lat_d = lat_q - LW'(1);
        end else begin
          busy_d = 1'b0;
          if (in_range_c) begin
            rd_valid_d = 1'b1;
            data_d     = burst_c;
            if (cnt_sum_c >= CW'(DEPTH)) begin
              done_d  = 1'b1;
              cnt_d   = '0;
              timer_d = TW'(DELAY - 1);
              state_d = REPEAT ? S_COUNT : S_HALT;
            end else begin
              cnt_d = cnt_sum_c;
            end
          end else begin
            rd_err_d = 1'b1;
          end
        end
      end
      S_HALT: begin
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_COUNT;
      timer_q     <= TW'(DELAY - 1);
      lat_q       <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      interrupt_q <= 1'b0;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WORD_SIZE'(INIT_BASE + i);
      end
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      lat_q       <= lat_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      interrupt_q <= interrupt_d;
      busy_q      <= busy_d;
      rd_valid_q  <= rd_valid_d;
      rd_err_q    <= rd_err_d;
      done_q      <= done_d;
      data_q      <= data_d;
    end
  end

  assign interrupt = interrupt_q;
  assign busy      = busy_q;
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;
  assign data      = data_q;
  assign done      = done_q;

endmodule

// File: doc/ext_dma_device.md
EXT_DMA_DEVICE -- requirements
Module: ext_dma_device

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- WORD_SIZE, 16, bits per memory word.
- DEPTH, 12, number of words the device holds and delivers per transfer (max 256).
- BURST_LEN, 4, words returned per read.
- DELAY, 64, cycles from reset release or rearm to the interrupt being raised (DELAY >= 2).
- READ_LAT, 2, cycles from an accepted rd_req to rd_valid (READ_LAT >= 1).
- INIT_BASE, 16'h0100, reset pattern base.
- REPEAT, 0, 1 = rearm after each completed transfer; 0 = halt after one transfer.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, clock, all logic on the rising edge.
- reset_n, in, 1, reset, synchronous, active-low.
- intr_ack, in, 1, CPU acknowledge of the interrupt.
- rd_req, in, 1, one-cycle read request.
- offset, in, WORD_SIZE, start word index, sampled with rd_req.
- interrupt, out, 1, device has data ready (level).
- busy, out, 1, a read is in flight.
- rd_valid, out, 1, one-cycle data-valid strobe.
- rd_err, out, 1, one-cycle out-of-range strobe.
- data, out, WORD_SIZE*BURST_LEN, burst data.
- done, out, 1, one-cycle strobe when the transfer is complete.

Function
REQ-003 The FSM SHALL have four states: COUNT, INTR, SERVE and HALT.
REQ-004 In COUNT, the down-counter SHALL decrement once per cycle; on the cycle it reaches 0, the next state SHALL be INTR and interrupt SHALL be registered to 1.
REQ-005 In INTR, interrupt SHALL stay 1 until intr_ack is sampled 1; the next cycle SHALL then have interrupt=0 and state SERVE.
REQ-006 intr_ack SHALL be ignored in every state except INTR.
REQ-007 rd_req SHALL be accepted only in SERVE with busy=0; a request in any other state or while busy=1 SHALL be dropped with no response.
REQ-008 On acceptance, offset SHALL be latched and busy SHALL be 1 from the next cycle until the response cycle inclusive.
REQ-009 The response SHALL occur exactly READ_LAT cycles after the acceptance edge.
REQ-010 If offset+BURST_LEN <= DEPTH (computed at least 17 bits wide, no wrap), the response SHALL be: rd_valid=1 and data={mem[offset], mem[offset+1], ..., mem[offset+BURST_LEN-1]}, with mem[offset] in the MSBs.
REQ-011 Otherwise the response SHALL be rd_err=1, with data and the delivered count unchanged.
REQ-012 data SHALL hold its last valid value between responses.
REQ-013 The delivered count SHALL increase by BURST_LEN on each rd_valid; repeat reads of the same offset SHALL also count.
REQ-014 On the rd_valid that makes the count >= DEPTH, done SHALL pulse in the same cycle and the count SHALL clear.
REQ-015 After that completing rd_valid, the next state SHALL be COUNT with the counter reloaded to DELAY-1 if REPEAT=1, and HALT if REPEAT=0.
REQ-016 HALT SHALL be left only by reset; all requests in HALT SHALL be dropped.
REQ-017 rd_valid, rd_err and done SHALL never be asserted for more than one consecutive cycle from a single request.
REQ-018 rd_valid and rd_err SHALL be mutually exclusive.
REQ-019 Memory contents SHALL be read-only after reset.

Reset
REQ-020 While reset_n=0 at a clock edge, the block SHALL set:
- state=COUNT, counter=DELAY-1;
- interrupt=0, busy=0, rd_valid=0, rd_err=0, done=0;
- data=0, delivered count=0;
- mem[i]=INIT_BASE+i for 0 <= i < DEPTH.
REQ-021 A reset mid-read SHALL cancel the pending response; no rd_valid or rd_err SHALL follow it.
REQ-022 A reset in INTR SHALL drop interrupt at the next edge.

Verification
REQ-023 The bench SHALL cover the following scenarios with default parameters:
- Release reset at edge 0 -> interrupt=0 through edge 63 and interrupt=1 after edge 64; pulse intr_ack -> interrupt=0 the next cycle.
- In SERVE, rd_req offset=0 -> busy for 2 cycles, then rd_valid with data=64'h0100_0101_0102_0103.
- Reads at offsets 0, 4 and 8 -> data at offset 8 is 64'h0108_0109_010A_010B, with done pulsing in the same cycle; state HALT; a later rd_req gives no response.
- rd_req offset=9 -> rd_err one pulse, data unchanged, done never pulses; rd_req offset=16'hFFFE -> rd_err (no wrap).
- rd_req during COUNT, during INTR and while busy -> no rd_valid or rd_err; intr_ack during COUNT -> interrupt still rises at edge 64.
- REPEAT=1 -> after done, interrupt rises again 64 cycles later; reset_n=0 one cycle after an accepted rd_req -> no rd_valid, all outputs 0.
